lif_neuron: RTL and testbench

Postsynaptic leaky integrate-and-fire neuron terminating up to N_SYN `synapse` outputs. Detects each synapse's rising edge and adds or subtracts that synapse's weight to a saturating membrane potential, with a shift-based leak each cycle. On threshold crossing it emits a one-cycle spike, resets the membrane and enters a fixed refractory period. Its spike_out feeds downstream synapses' spike_input, closing the oscillator loop.

---
 rtl/lif_neuron.sv | 185 ++++++++++++++++++
 tb/tb_lif_neuron.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron.sv
// -----------------------------------------------------------------------------
// lif_neuron
//
// Postsynaptic leaky integrate-and-fire neuron. Each synapse input is a level;
// its rising edge adds (excitatory) or subtracts (inhibitory) that synapse's
// weight to a saturating membrane potential, which also leaks by
// membrane >> LEAK_SHIFT every integrating cycle. Reaching THRESHOLD emits a
// one-cycle spike, clears the membrane and holds it at zero for
// REFRACT_CYCLES cycles before integration resumes.
//
// Optional feature macro: LIF_SPIKE_COUNT_EN
//   defined   -> spike_count counts FIRE cycles, saturating at 16'hFFFF
//   undefined -> spike_count is tied to zero, no counter flops
//
// Ports:
//   clk          in   1          clock, all logic on posedge
//   reset        in   1          synchronous, active-high
//   syn_in       in   N_SYN      presynaptic level inputs
//   syn_weight   in   N_SYN*WW   weight i at [i*WW +: WW], unsigned magnitude
//   spike_out    out  1          one-cycle fire pulse, registered
//   membrane     out  W          membrane potential, registered
//   refractory   out  1          high while refractory, registered
//   spike_count  out  16         fired-spike counter (see macro above)
// -----------------------------------------------------------------------------
module lif_neuron #(
    parameter int               N_SYN          = 4,
    parameter int               W              = 8,
    parameter int               WW             = 4,
    parameter int               THRESHOLD      = 200,
    parameter int               LEAK_SHIFT     = 3,
    parameter int               REFRACT_CYCLES = 4,
    parameter logic [N_SYN-1:0] INH_MASK       = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_SYN-1:0]    syn_in,
    input  logic [N_SYN*WW-1:0] syn_weight,
    output logic                spike_out,
    output logic [W-1:0]        membrane,
    output logic                refractory,
    output logic [15:0]         spike_count
);

    // Signed working width: wide enough for the leaked membrane plus N_SYN
    // full-scale weights of either sign without overflow.
    localparam int SW = W + WW + 4;

    localparam logic signed [SW-1:0] MEM_MAX      = SW'((1 << W) - 1);
    localparam logic [W-1:0]         THRESH       = W'(THRESHOLD);
    localparam logic [3:0]           REFRACT_LOAD = 4'((REFRACT_CYCLES == 0) ? 0 : REFRACT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_INTEGRATE,
        ST_FIRE,
        ST_REFRACT
    } state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     membrane_q, membrane_d;
    logic [3:0]       rcnt_q, rcnt_d;
    logic [N_SYN-1:0] syn_prev_q;
    logic             spike_q;
    logic             refr_q;

    logic [N_SYN-1:0]     rise;
    logic signed [SW-1:0] mem_ext;
    logic signed [SW-1:0] sum;
    logic [W-1:0]         next_mem;

    // A level held high counts once; syn_prev tracks the inputs in every state,
    // so levels held across FIRE/REFRACT are not seen as rises afterwards.
    assign rise = syn_in & ~syn_prev_q;

    // -------------------------------------------------------------------------
    // Integration datapath: leak, net all rises in one sum, then clamp.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        mem_ext  = $signed({{(SW-W){1'b0}}, membrane_q});
        sum      = mem_ext - (mem_ext >>> LEAK_SHIFT);
        next_mem = '0;
        for (int i = 0; i < N_SYN; i++) begin
            if (rise[i]) begin
                if (INH_MASK[i]) begin
                    sum = sum - $signed({{(SW-WW){1'b0}}, syn_weight[i*WW +: WW]});
                end else begin
                    sum = sum + $signed({{(SW-WW){1'b0}}, syn_weight[i*WW +: WW]});
                end
            end
        end
        if (sum[SW-1]) begin
            next_mem = '0;
        end else if (sum > MEM_MAX) begin
            next_mem = '1;
        end else begin
            next_mem = sum[W-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        membrane_d = membrane_q;
        rcnt_d     = rcnt_q;
        case (state_q)
            ST_INTEGRATE: begin
                if (next_mem >= THRESH) begin
                    membrane_d = '0;
                    state_d    = ST_FIRE;
                end else begin
                    membrane_d = next_mem;
                end
            end
            ST_FIRE: begin
                membrane_d = '0;
                if (REFRACT_CYCLES == 0) begin
                    state_d = ST_INTEGRATE;
                end else begin
                    state_d = ST_REFRACT;
                    rcnt_d  = REFRACT_LOAD;
                end
            end
            ST_REFRACT: begin
                membrane_d = '0;
                if (rcnt_q == 4'd0) begin
                    state_d = ST_INTEGRATE;
                end else begin
                    rcnt_d = rcnt_q - 4'd1;
                end
            end
            default: begin
                state_d    = ST_INTEGRATE;
                membrane_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers. Outputs are decoded from the next state so
    // they line up cycle-for-cycle with the state register.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // sample their inputs from the same pre-edge values.
        if (reset) begin
            state_q    <= ST_INTEGRATE;
            membrane_q <= '0;
            rcnt_q     <= '0;
            syn_prev_q <= '0;
            spike_q    <= 1'b0;
            refr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            membrane_q <= membrane_d;
            rcnt_q     <= rcnt_d;
            syn_prev_q <= syn_in;
            spike_q    <= (state_d == ST_FIRE);
            refr_q     <= (state_d == ST_REFRACT);
        end
    end

    assign spike_out  = spike_q;
    assign membrane   = membrane_q;
    assign refractory = refr_q;

`ifdef LIF_SPIKE_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (state_q == ST_FIRE && count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign spike_count = count_q;
`else
    assign spike_count = 16'h0000;
`endif

endmodule

// File: tb/tb_lif_neuron.sv
// -----------------------------------------------------------------------------
// tb_lif_neuron
//
// Two neurons share one stimulus stream: A (THRESHOLD 40, synapse 3
// inhibitory) and B (THRESHOLD 255, all excitatory). The driver applies inputs
// on the falling edge, advances a timeline-based reference model and queues the
// expected post-edge outputs; the monitor pops and compares after each rising
// edge.
// -----------------------------------------------------------------------------
module tb_lif_neuron;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int WW   = 4;
    localparam int LS   = 3;
    localparam int RC   = 4;
    localparam int TH_A = 40;
    localparam int TH_B = 255;
    localparam logic [N-1:0] MASK_A = 4'b1000;
    localparam logic [N-1:0] MASK_B = 4'b0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset      = 1'b1;
    logic [N-1:0]    syn_in     = '0;
    logic [N*WW-1:0] syn_weight = '0;

    logic         spike_a, refr_a, spike_b, refr_b;
    logic [W-1:0] mem_a, mem_b;
    logic [15:0]  cnt_a, cnt_b;

    lif_neuron #(
        .N_SYN(N), .W(W), .WW(WW), .THRESHOLD(TH_A), .LEAK_SHIFT(LS),
        .REFRACT_CYCLES(RC), .INH_MASK(MASK_A)
    ) dut_a (
        .clk(clk), .reset(reset), .syn_in(syn_in), .syn_weight(syn_weight),
        .spike_out(spike_a), .membrane(mem_a), .refractory(refr_a), .spike_count(cnt_a)
    );

    lif_neuron #(
        .N_SYN(N), .W(W), .WW(WW), .THRESHOLD(TH_B), .LEAK_SHIFT(LS),
        .REFRACT_CYCLES(RC), .INH_MASK(MASK_B)
    ) dut_b (
        .clk(clk), .reset(reset), .syn_in(syn_in), .syn_weight(syn_weight),
        .spike_out(spike_b), .membrane(mem_b), .refractory(refr_b), .spike_count(cnt_b)
    );

    typedef struct {
        int mem;
        int spike;
        int refr;
        int cnt;
    } obs_t;

    typedef struct {
        obs_t a;
        obs_t b;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // ---------------------------------------------------------------- model
    // Per neuron: membrane value, cycles elapsed since the last fire edge
    // (-1 = never fired), and fired-spike total.
    int           m_mem   [2];
    int           m_since [2];
    int           m_cnt   [2];
    int           m_th    [2];
    logic [N-1:0] m_mask  [2];
    logic [N-1:0] m_prev;

    function automatic obs_t model_obs(input int k);
        obs_t o;
        o.mem   = m_mem[k];
        o.spike = (m_since[k] == 0) ? 1 : 0;
        o.refr  = (m_since[k] >= 1 && m_since[k] <= RC) ? 1 : 0;
`ifdef LIF_SPIKE_COUNT_EN
        o.cnt   = m_cnt[k];
`else
        o.cnt   = 0;
`endif
        return o;
    endfunction

    task automatic model_edge(input logic rst, input logic [N-1:0] in, input logic [N*WW-1:0] wts);
        logic [N-1:0] rise;
        int           s;
        rise = in & ~m_prev;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_mem[k]   = 0;
                m_since[k] = -1;
                m_cnt[k]   = 0;
            end else begin
                if (m_since[k] == 0 && m_cnt[k] < 65535) m_cnt[k] = m_cnt[k] + 1;
                if (m_since[k] < 0 || m_since[k] > RC) begin
                    s = m_mem[k] - m_mem[k] / (1 << LS);
                    for (int i = 0; i < N; i++) begin
                        if (rise[i]) begin
                            if (m_mask[k][i]) s = s - int'(wts[i*WW +: WW]);
                            else              s = s + int'(wts[i*WW +: WW]);
                        end
                    end
                    if (s < 0)   s = 0;
                    if (s > 255) s = 255;
                    if (s >= m_th[k]) begin
                        m_mem[k]   = 0;
                        m_since[k] = 0;
                    end else begin
                        m_mem[k] = s;
                    end
                end else begin
                    m_since[k] = m_since[k] + 1;
                    m_mem[k]   = 0;
                end
            end
        end
        m_prev = rst ? '0 : in;
    endtask

    // --------------------------------------------------------------- driver
    task automatic drive(input logic rst, input logic [N-1:0] in, input logic [N*WW-1:0] wts);
        exp_t e;
        @(negedge clk);
        reset      = rst;
        syn_in     = in;
        syn_weight = wts;
        model_edge(rst, in, wts);
        e.a = model_obs(0);
        e.b = model_obs(1);
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // -------------------------------------------------------------- monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("a_membrane",    32'(mem_a),   e.a.mem);
                check("a_spike_out",   32'(spike_a), e.a.spike);
                check("a_refractory",  32'(refr_a),  e.a.refr);
                check("a_spike_count", 32'(cnt_a),   e.a.cnt);
                check("b_membrane",    32'(mem_b),   e.b.mem);
                check("b_spike_out",   32'(spike_b), e.b.spike);
                check("b_refractory",  32'(refr_b),  e.b.refr);
                check("b_spike_count", 32'(cnt_b),   e.b.cnt);
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    localparam logic [N*WW-1:0] W5  = {4{4'd5}};
    localparam logic [N*WW-1:0] W10 = {4{4'd10}};
    localparam logic [N*WW-1:0] W15 = {4{4'd15}};

    initial begin
        int budget;
        m_th[0]   = TH_A;
        m_th[1]   = TH_B;
        m_mask[0] = MASK_A;
        m_mask[1] = MASK_B;
        m_prev    = '0;
        for (int k = 0; k < 2; k++) begin
            m_mem[k]   = 0;
            m_since[k] = -1;
            m_cnt[k]   = 0;
        end

        // Reset state
        drive(1'b1, 4'b0000, '0);
        drive(1'b1, 4'b0000, '0);

        // Leak: single rise of weight 10 -> 10, 9, 8, 7, 7
        drive(1'b0, 4'b0001, W10);
        repeat (6) drive(1'b0, 4'b0001, W10);
        drive(1'b0, 4'b0000, W10);

        // Level hold: weight 5 held 20 cycles counts once
        drive(1'b1, 4'b0000, '0);
        repeat (20) drive(1'b0, 4'b0010, W5);
        repeat (3) drive(1'b0, 4'b0000, W5);

        // Fire on A, rises during spike/refractory toggled and ignored
        drive(1'b1, 4'b0000, '0);
        drive(1'b0, 4'b0111, W15);
        for (int i = 0; i < 6; i++) drive(1'b0, (i % 2 == 0) ? 4'b0000 : 4'b0111, W15);
        repeat (4) drive(1'b0, 4'b0111, W15);
        drive(1'b0, 4'b0000, W15);

        // Inhibit/clamp on A: build 7, inhibitory 15 -> 0; then +15 -15 from 7 -> 7
        drive(1'b1, 4'b0000, '0);
        repeat (5) drive(1'b0, 4'b0001, W10);
        drive(1'b0, 4'b1001, W15);
        drive(1'b0, 4'b0000, W15);
        repeat (5) drive(1'b0, 4'b0001, W10);
        drive(1'b0, 4'b0000, W10);
        drive(1'b0, 4'b1001, W15);
        repeat (2) drive(1'b0, 4'b0000, W15);

        // Saturate on B: repeated full-weight rises clamp at 255 and fire
        drive(1'b1, 4'b0000, '0);
        for (int i = 0; i < 40; i++) drive(1'b0, (i % 2 == 0) ? 4'b1111 : 4'b0000, W15);

        // Reset mid-refractory on A (second refractory cycle)
        drive(1'b1, 4'b0000, '0);
        drive(1'b0, 4'b0111, W15);
        drive(1'b0, 4'b0000, W15);
        drive(1'b0, 4'b0000, W15);
        drive(1'b1, 4'b0000, W15);
        repeat (3) drive(1'b0, 4'b0000, W15);

        // Three fires on A, then reset clears the counter
        for (int f = 0; f < 3; f++) begin
            drive(1'b0, 4'b0111, W15);
            repeat (6) drive(1'b0, 4'b0000, W15);
        end
        drive(1'b1, 4'b0000, '0);
        repeat (2) drive(1'b0, 4'b0000, '0);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 63) == 0), N'($urandom), (N*WW)'($urandom));
        end

        // Drain the scoreboard within a bounded number of cycles
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget = budget + 1;
        end
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL drain: %0d expected outputs never observed", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
